// File: rtl/ahb_sram_pkg.sv
// Shared encodings, FSM states and byte-lane helpers for the AHB-Lite SRAM slave.
package ahb_sram_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE = 3'd0;
  localparam logic [2:0] HSIZE_HALF = 3'd1;
  localparam logic [2:0] HSIZE_WORD = 3'd2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_WAIT,
    ST_RD_DATA,
    ST_WR_DATA,
    ST_ERR1,
    ST_ERR2
  } state_e;

  // Byte-lane payload: write buffer contents and the captured read-hazard overlay.
  typedef struct packed {
    logic [3:0]  mask;
    logic [31:0] data;
  } lane_data_t;

  // Lane enables; unaligned halfwords/words are forced onto their aligned lanes.
  function automatic logic [3:0] byte_mask(input logic [2:0] size, input logic [1:0] addr_lo);
    case (size)
      HSIZE_BYTE: byte_mask = 4'b0001 << addr_lo;
      HSIZE_HALF: byte_mask = addr_lo[1] ? 4'b1100 : 4'b0011;
      default:    byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] array_word,
                                              input logic [31:0] buf_word,
                                              input logic [3:0]  mask);
    for (int i = 0; i < 4; i++)
      merge_bytes[8*i +: 8] = mask[i] ? buf_word[8*i +: 8] : array_word[8*i +: 8];
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    misaligned = (size > HSIZE_WORD) ||
                 ((size == HSIZE_HALF) && addr_lo[0]) ||
                 ((size == HSIZE_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/ahb_sram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the SRAM controller.
interface ahb_sram_ctrl_if;
  logic        HSEL;
  logic        HREADY;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic [2:0]  HSIZE;
  logic [31:0] HWDATA;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;

  modport master (output HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                  input  HREADYOUT, HRDATA, HRESP);
  modport slave  (input  HSEL, HREADY, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
                  output HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/sram_sp_bw.sv
// Single-port synchronous 32-bit array with byte write enables and registered read.
// Interface kept macro-compatible so a foundry SRAM can drop in.
module sram_sp_bw #(
  parameter int unsigned AW = 10
) (
  input  logic          HCLK,
  input  logic          en,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  localparam int unsigned DEPTH = 32'(1) << AW;

  logic [31:0] mem [DEPTH];

  always_ff @(posedge HCLK) begin
    if (en) begin
      if (we == 4'b0000) begin
        rdata <= mem[addr];
      end else begin
        for (int i = 0; i < 4; i++)
          if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end
endmodule

// File: rtl/ahb_sram_ctrl.sv
// AHB-Lite SRAM slave: zero-wait writes via a one-entry buffer, programmable read waits.
// Define AHB_SRAM_ALIGN_CHECK_EN to return a two-cycle ERROR for oversize/misaligned transfers.
module ahb_sram_ctrl
  import ahb_sram_pkg::*;
#(
  parameter int unsigned MEMWIDTH    = 12,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic          HCLK,
  input  logic          HRESET,
  ahb_sram_ctrl_if.slave bus
);
  localparam int unsigned AW       = MEMWIDTH - 2;
  // A read deferred behind a buffer drain needs at least one wait cycle.
  localparam int unsigned WAIT_LIM = (WAIT_STATES == 0) ? 1 : WAIT_STATES;

  state_e        state_q, state_d;
  logic [2:0]    cnt_q, cnt_d;
  logic          pend_q, buf_valid_q;
  logic          hreadyout_q, hreadyout_d, hresp_q, hresp_d;
  logic [AW-1:0] addr_q, buf_addr_q;
  logic [3:0]    mask_q;
  lane_data_t    buf_q, hit_q, hit_d, eff_c;
  logic [31:0]   sram_rdata;

  logic          req_c, bad_c, rd_req_c, defer_c, rd_issue_c, commit_c, eff_valid_c;
  logic [AW-1:0] haddr_w_c, rd_addr_c, eff_addr_c;
  logic [3:0]    mask_c;
  logic          unused_c;

  assign unused_c  = ^{bus.HADDR[31:MEMWIDTH], bus.HTRANS[0]};
  assign haddr_w_c = bus.HADDR[MEMWIDTH-1:2];
  assign mask_c    = byte_mask(bus.HSIZE, bus.HADDR[1:0]);
  assign req_c     = bus.HSEL & bus.HREADY & bus.HTRANS[1] &
                     (state_q inside {ST_IDLE, ST_RD_DATA, ST_WR_DATA, ST_ERR2});
`ifdef AHB_SRAM_ALIGN_CHECK_EN
  assign bad_c     = misaligned(bus.HSIZE, bus.HADDR[1:0]);
`else
  assign bad_c     = 1'b0;
`endif

  // SRAM port arbitration: reads win, a valid buffer drains on any other cycle.
  assign rd_req_c   = req_c & ~bus.HWRITE & ~bad_c;
  assign defer_c    = rd_req_c & (state_q == ST_WR_DATA) & buf_valid_q;
  assign rd_issue_c = (rd_req_c & ~defer_c) | ((state_q == ST_RD_WAIT) & pend_q);
  assign rd_addr_c  = (state_q == ST_RD_WAIT) ? addr_q : haddr_w_c;
  assign commit_c   = buf_valid_q & ~rd_issue_c & ~HRESET;

  // The write in its data phase is the buffer content the read must see.
  assign eff_valid_c = (state_q == ST_WR_DATA) | buf_valid_q;
  assign eff_addr_c  = (state_q == ST_WR_DATA) ? addr_q : buf_addr_q;
  assign eff_c       = (state_q == ST_WR_DATA) ? lane_data_t'{mask: mask_q, data: bus.HWDATA} : buf_q;

  always_comb begin
    hit_d      = eff_c;
    hit_d.mask = (eff_valid_c && (eff_addr_c == rd_addr_c)) ? eff_c.mask : 4'b0000;
  end

  sram_sp_bw #(.AW(AW)) u_sram (
    .HCLK  (HCLK),
    .en    (rd_issue_c | commit_c),
    .we    (commit_c ? buf_q.mask : 4'b0000),
    .addr  (rd_issue_c ? rd_addr_c : buf_addr_q),
    .wdata (buf_q.data),
    .rdata (sram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_RD_WAIT: begin
        if (cnt_q == 3'(WAIT_LIM - 1)) state_d = ST_RD_DATA;
        else                           cnt_d   = cnt_q + 3'd1;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 3'd0;
        if (req_c) begin
          if (bad_c)                                state_d = ST_ERR1;
          else if (bus.HWRITE)                      state_d = ST_WR_DATA;
          else if ((WAIT_STATES == 0) && !defer_c)  state_d = ST_RD_DATA;
          else                                      state_d = ST_RD_WAIT;
        end
      end
    endcase
    hreadyout_d = !(state_d inside {ST_RD_WAIT, ST_ERR1});
`ifdef AHB_SRAM_ALIGN_CHECK_EN
    hresp_d     = state_d inside {ST_ERR1, ST_ERR2};
`else
    hresp_d     = 1'b0;
`endif
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 3'd0;
      pend_q      <= 1'b0;
      buf_valid_q <= 1'b0;
      hreadyout_q <= 1'b1;
      hresp_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= defer_c | (pend_q & ~rd_issue_c);
      buf_valid_q <= (state_q == ST_WR_DATA) | (buf_valid_q & ~commit_c);
      hreadyout_q <= hreadyout_d;
      hresp_q     <= hresp_d;
    end
  end

  // Datapath captures need no reset; qualifying state above gates their use.
  always_ff @(posedge HCLK) begin
    if (req_c) begin
      addr_q <= haddr_w_c;
      mask_q <= mask_c;
    end
    if (state_q == ST_WR_DATA) begin
      buf_addr_q <= addr_q;
      buf_q      <= lane_data_t'{mask: mask_q, data: bus.HWDATA};
    end
    if (rd_issue_c) hit_q <= hit_d;
  end

  assign bus.HREADYOUT = hreadyout_q;
  assign bus.HRESP     = hresp_q;
  assign bus.HRDATA    = (state_q == ST_RD_DATA) ? merge_bytes(sram_rdata, hit_q.data, hit_q.mask)
                                                 : 32'h0;
endmodule

// File: tb/tb_ahb_sram_ctrl.sv
// Directed bench for ahb_sram_ctrl: three instances with 0, 2 and 3 read wait states.
module tb_ahb_sram_ctrl;
  import ahb_sram_pkg::*;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [2:0]  hsel;
  logic [31:0] haddr, hwdata;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  int          dsel;
  logic        obs_ready, obs_resp;
  logic [31:0] obs_rdata;
  int          errors = 0;
  int          checks = 0;

  always #5 HCLK = ~HCLK;

  ahb_sram_ctrl_if if0 ();
  ahb_sram_ctrl_if if1 ();
  ahb_sram_ctrl_if if2 ();

  assign if0.HSEL = hsel[0]; assign if0.HREADY = if0.HREADYOUT; assign if0.HADDR = haddr;
  assign if0.HTRANS = htrans; assign if0.HWRITE = hwrite; assign if0.HSIZE = hsize; assign if0.HWDATA = hwdata;
  assign if1.HSEL = hsel[1]; assign if1.HREADY = if1.HREADYOUT; assign if1.HADDR = haddr;
  assign if1.HTRANS = htrans; assign if1.HWRITE = hwrite; assign if1.HSIZE = hsize; assign if1.HWDATA = hwdata;
  assign if2.HSEL = hsel[2]; assign if2.HREADY = if2.HREADYOUT; assign if2.HADDR = haddr;
  assign if2.HTRANS = htrans; assign if2.HWRITE = hwrite; assign if2.HSIZE = hsize; assign if2.HWDATA = hwdata;

  ahb_sram_ctrl #(.MEMWIDTH(12), .WAIT_STATES(0)) u_dut0 (.HCLK(HCLK), .HRESET(HRESET), .bus(if0));
  ahb_sram_ctrl #(.MEMWIDTH(12), .WAIT_STATES(2)) u_dut1 (.HCLK(HCLK), .HRESET(HRESET), .bus(if1));
  ahb_sram_ctrl #(.MEMWIDTH(12), .WAIT_STATES(3)) u_dut2 (.HCLK(HCLK), .HRESET(HRESET), .bus(if2));

  always_comb begin
    case (dsel)
      1:       begin obs_ready = if1.HREADYOUT; obs_resp = if1.HRESP; obs_rdata = if1.HRDATA; end
      2:       begin obs_ready = if2.HREADYOUT; obs_resp = if2.HRESP; obs_rdata = if2.HRDATA; end
      default: begin obs_ready = if0.HREADYOUT; obs_resp = if0.HRESP; obs_rdata = if0.HRDATA; end
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic drv_addr(input int u, input logic w, input logic [2:0] sz, input logic [31:0] a);
    dsel   = u;
    hsel   = 3'b001 << u;
    htrans = HTRANS_NONSEQ;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
  endtask

  task automatic drv_idle();
    hsel   = 3'b000;
    htrans = HTRANS_IDLE;
    hwrite = 1'b0;
  endtask

  // Bounded wait for the current data phase to complete.
  task automatic wait_ready(input string tag);
    int n = 0;
    while (obs_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(obs_ready), 32'd1);
  endtask

  task automatic do_write(input int u, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d);
    drv_addr(u, 1'b1, sz, a);
    tick();
    hwdata = d;
    drv_idle();
    tick();
  endtask

  task automatic do_read(input int u, input logic [31:0] a, input logic [31:0] exp, input string tag);
    drv_addr(u, 1'b0, HSIZE_WORD, a);
    tick();
    drv_idle();
    wait_ready({tag, "_ready"});
    check(tag, obs_rdata, exp);
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    HRESET = 1'b1; dsel = 0; hwdata = 32'h0; haddr = 32'h0; hsize = HSIZE_WORD;
    drv_idle();
    tick(); tick();
    check("rst_ready", 32'(obs_ready), 32'd1);
    check("rst_resp",  32'(obs_resp),  32'd0);
    check("rst_rdata", obs_rdata,      32'h0);
    HRESET = 1'b0;
    tick();

    // Write then immediate read: data merged from the buffer, no wait state
    drv_addr(0, 1'b1, HSIZE_WORD, 32'h100); tick();
    hwdata = 32'hDEADBEEF; drv_addr(0, 1'b0, HSIZE_WORD, 32'h100);
    check("wr_dphase_ready", 32'(obs_ready), 32'd1); tick();
    drv_idle();
    check("rd_buf_ready", 32'(obs_ready), 32'd1);
    check("rd_buf_data",  obs_rdata,      32'hDEADBEEF); tick();

    // Byte write into lane 1 only, read merged, then from the array after commit
    drv_addr(0, 1'b1, HSIZE_BYTE, 32'h101); tick();
    hwdata = 32'hFFFF5AFF; drv_addr(0, 1'b0, HSIZE_WORD, 32'h100); tick();
    drv_idle();
    check("rd_byte_merge", obs_rdata, 32'hDEAD5AEF); tick();
    tick(); tick(); tick();
    do_read(0, 32'h100, 32'hDEAD5AEF, "rd_commit");

    // IDLE and BUSY with HSEL get a zero-wait OKAY
    dsel = 0; hsel = 3'b001; htrans = HTRANS_IDLE; tick();
    check("idle_sel_ready", 32'(obs_ready), 32'd1);
    htrans = HTRANS_BUSY; tick();
    check("busy_sel_ready", 32'(obs_ready), 32'd1);
    check("busy_sel_resp",  32'(obs_resp),  32'd0);
    drv_idle(); tick();

    // Back-to-back writes, idle, pipelined reads
    drv_addr(0, 1'b1, HSIZE_WORD, 32'h10); tick();
    hwdata = 32'h11111111; drv_addr(0, 1'b1, HSIZE_WORD, 32'h14); tick();
    hwdata = 32'h22222222; drv_addr(0, 1'b1, HSIZE_WORD, 32'h18); tick();
    hwdata = 32'h33333333; drv_idle(); tick(); tick();
    drv_addr(0, 1'b0, HSIZE_WORD, 32'h10); tick();
    drv_addr(0, 1'b0, HSIZE_WORD, 32'h14);
    check("b2b_rd10", obs_rdata, 32'h11111111); tick();
    drv_addr(0, 1'b0, HSIZE_WORD, 32'h18);
    check("b2b_rd14", obs_rdata, 32'h22222222); tick();
    drv_idle();
    check("b2b_rd18", obs_rdata, 32'h33333333); tick();

    // Read right behind two writes: both writes survive
    drv_addr(0, 1'b1, HSIZE_WORD, 32'h20); tick();
    hwdata = 32'hAAAA0001; drv_addr(0, 1'b1, HSIZE_WORD, 32'h24); tick();
    hwdata = 32'hBBBB0002; drv_addr(0, 1'b0, HSIZE_WORD, 32'h20); tick();
    drv_idle();
    wait_ready("wwr_ready");
    check("wwr_rd20", obs_rdata, 32'hAAAA0001); tick();
    do_read(0, 32'h24, 32'hBBBB0002, "wwr_rd24");

    // Buffered write to another word is invisible to this read
    do_write(0, 32'h34, HSIZE_WORD, 32'h34343434); tick();
    drv_addr(0, 1'b1, HSIZE_WORD, 32'h30); tick();
    hwdata = 32'hC0C0C0C0; drv_addr(0, 1'b0, HSIZE_WORD, 32'h34); tick();
    drv_idle();
    check("vis_rd34", obs_rdata, 32'h34343434); tick();
    do_read(0, 32'h30, 32'hC0C0C0C0, "vis_rd30");

    // Halfword lanes and address aliasing above MEMWIDTH
    do_write(0, 32'h102, HSIZE_HALF, 32'h77771234);
    do_read(0, 32'h1100, 32'h77775AEF, "alias_hw_hi");
    do_write(0, 32'h100, HSIZE_HALF, 32'hFFFFC3C3);
    do_read(0, 32'h100, 32'h7777C3C3, "hw_lo");

`ifdef AHB_SRAM_ALIGN_CHECK_EN
    drv_addr(0, 1'b1, HSIZE_HALF, 32'h103); tick();
    hwdata = 32'h99990000; drv_idle();
    check("err1_ready", 32'(obs_ready), 32'd0);
    check("err1_resp",  32'(obs_resp),  32'd1); tick();
    check("err2_ready", 32'(obs_ready), 32'd1);
    check("err2_resp",  32'(obs_resp),  32'd1);
    check("err2_rdata", obs_rdata,      32'h0); tick();
    check("err_done_resp", 32'(obs_resp), 32'd0);
    do_read(0, 32'h100, 32'h7777C3C3, "err_unchanged");
`else
    do_write(0, 32'h103, HSIZE_HALF, 32'h99990000);
    check("unal_resp", 32'(obs_resp), 32'd0);
    do_read(0, 32'h100, 32'h9999C3C3, "unal_hw_forced");
`endif

    // Two read wait states
    do_write(1, 32'h200, HSIZE_WORD, 32'h12345678); tick();
    drv_addr(1, 1'b0, HSIZE_WORD, 32'h200); tick();
    drv_idle();
    check("ws2_w1_ready", 32'(obs_ready), 32'd0);
    check("ws2_w1_rdata", obs_rdata,      32'h0); tick();
    check("ws2_w2_ready", 32'(obs_ready), 32'd0); tick();
    check("ws2_d_ready",  32'(obs_ready), 32'd1);
    check("ws2_d_resp",   32'(obs_resp),  32'd0);
    check("ws2_d_rdata",  obs_rdata,      32'h12345678); tick();

    // Reset in the second wait cycle discards the buffered write
    do_write(2, 32'h300, HSIZE_WORD, 32'h0BAD0BAD); tick();
    drv_addr(2, 1'b1, HSIZE_WORD, 32'h304); tick();
    hwdata = 32'h11223344; drv_addr(2, 1'b1, HSIZE_WORD, 32'h300); tick();
    hwdata = 32'hFEEDFACE; drv_addr(2, 1'b0, HSIZE_WORD, 32'h308); tick();
    drv_idle();
    check("rstw_w1_ready", 32'(obs_ready), 32'd0); tick();
    check("rstw_w2_ready", 32'(obs_ready), 32'd0);
    HRESET = 1'b1; tick();
    HRESET = 1'b0;
    check("rstw_ready", 32'(obs_ready), 32'd1);
    check("rstw_resp",  32'(obs_resp),  32'd0);
    check("rstw_rdata", obs_rdata,      32'h0);
    do_read(2, 32'h300, 32'h0BAD0BAD, "rstw_discard");
    do_read(2, 32'h304, 32'h11223344, "rstw_kept");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
